// File: rtl/pwm_pkg.sv
// Shared constants, state encoding and duty clamp helper for the PWM timebase.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH       = 7;
  localparam int unsigned PWM_TOP_DEFAULT = 99;
  localparam int unsigned PWM_PRESCALE_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pwm_state_e;

  // Largest storable duty: one past the last count, meaning never matched (100 %).
  function automatic int unsigned pwm_clamp_limit(input int unsigned top);
    return top + 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Count-tick generator: one tick every PRESCALE clocks while enabled, restarts when disabled.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick_c
);

  localparam logic [PWM_PRESCALE_W-1:0] LAST = PWM_PRESCALE_W'(PRESCALE - 1);

  logic [PWM_PRESCALE_W-1:0] cnt_q;
  logic [PWM_PRESCALE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PWM_PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = en && (cnt_q == LAST);

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: timer count TCR, period-start strobe E, double-buffered compare CCR.
// Optional prescaled count tick is built when PWM_PRESCALE_EN is defined.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned TOP      = PWM_TOP_DEFAULT,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic [WIDTH-1:0] DUTY_IN,
  input  logic             DUTY_VALID,
  output logic             DUTY_READY,
  output logic [WIDTH-1:0] TCR,
  output logic [WIDTH-1:0] CCR,
  output logic             E
);

  localparam logic [WIDTH-1:0] TOP_W = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(pwm_clamp_limit(TOP));

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] tcr_q, tcr_d;
  logic [WIDTH-1:0] ccr_q, ccr_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             e_q, e_d;
  logic             tick_c;
  logic [WIDTH-1:0] duty_clamped_c;

`ifdef PWM_PRESCALE_EN
  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (state_q == COUNT),
    .tick_c (tick_c)
  );
`else
  logic [31:0] prescale_unused;
  assign prescale_unused = 32'(PRESCALE);
  assign tick_c          = 1'b1;
`endif

  assign duty_clamped_c = (DUTY_IN > LIMIT) ? LIMIT : DUTY_IN;

  // Next-state, timer, transfer and handshake logic.
  always_comb begin
    state_d = state_q;
    tcr_d   = tcr_q;
    ccr_d   = ccr_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    e_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tcr_d = '0;
        if (!ready_q) begin
          ccr_d   = pend_q;
          ready_d = 1'b1;
        end
        if (RUN) begin
          state_d = COUNT;
          e_d     = 1'b1;
        end
      end
      COUNT: begin
        if (!RUN) begin
          state_d = IDLE;
          tcr_d   = '0;
        end else if (tick_c) begin
          if (tcr_q == TOP_W) begin
            tcr_d = '0;
            e_d   = 1'b1;
            // Compare value only changes together with the wrap to zero.
            if (!ready_q) begin
              ccr_d   = pend_q;
              ready_d = 1'b1;
            end
          end else begin
            tcr_d = tcr_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tcr_d   = '0;
      end
    endcase

    // Accept needs an empty buffer, so it never collides with a transfer.
    if (DUTY_VALID && ready_q) begin
      pend_d  = duty_clamped_c;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tcr_q   <= '0;
      ccr_q   <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tcr_q   <= tcr_d;
      ccr_q   <= ccr_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      e_q     <= e_d;
    end
  end

  assign TCR        = tcr_q;
  assign CCR        = ccr_q;
  assign E          = e_q;
  assign DUTY_READY = ready_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: cycle-by-cycle model comparison plus directed literal checks.
module tb_pwm_timebase;

  localparam int unsigned WIDTH = 7;
  localparam int unsigned TOP   = 99;
`ifdef PWM_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam int PERIOD_CLK = PS * (TOP + 1);

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             RUN = 1'b0;
  logic [WIDTH-1:0] DUTY_IN = '0;
  logic             DUTY_VALID = 1'b0;
  logic             DUTY_READY;
  logic [WIDTH-1:0] TCR;
  logic [WIDTH-1:0] CCR;
  logic             E;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  pwm_timebase #(
    .WIDTH    (WIDTH),
    .TOP      (TOP),
    .PRESCALE (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RUN        (RUN),
    .DUTY_IN    (DUTY_IN),
    .DUTY_VALID (DUTY_VALID),
    .DUTY_READY (DUTY_READY),
    .TCR        (TCR),
    .CCR        (CCR),
    .E          (E)
  );

  always #5 CLK = ~CLK;

  // Model: m_pos = clocks spent counting since RUN entry (-1 when idle), one-deep pending queue.
  int m_pos = -1;
  int m_ccr = 0;
  int m_pend[$];
  bit m_acc;
  int m_val;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pos = -1;
      m_ccr = 0;
      m_pend.delete();
    end else begin
      m_acc = DUTY_VALID && (m_pend.size() == 0);
      m_val = (int'(DUTY_IN) > TOP + 1) ? TOP + 1 : int'(DUTY_IN);
      if (m_pos < 0) begin
        if (m_pend.size() != 0) m_ccr = m_pend.pop_front();
        if (RUN) m_pos = 0;
      end else if (!RUN) begin
        m_pos = -1;
      end else begin
        m_pos++;
        if ((m_pos % PERIOD_CLK == 0) && (m_pend.size() != 0)) m_ccr = m_pend.pop_front();
      end
      if (m_acc) m_pend.push_back(m_val);
    end
  end

  function automatic int exp_tcr();
    return (m_pos < 0) ? 0 : (m_pos / PS) % (TOP + 1);
  endfunction

  function automatic int exp_e();
    return ((m_pos >= 0) && (m_pos % PERIOD_CLK == 0)) ? 1 : 0;
  endfunction

  function automatic int exp_ready();
    return (m_pend.size() == 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge CLK);
    if (chk_en) begin
      check("model_tcr",   32'(TCR),        exp_tcr());
      check("model_ccr",   32'(CCR),        m_ccr);
      check("model_e",     32'(E),          exp_e());
      check("model_ready", 32'(DUTY_READY), exp_ready());
    end
  endtask

  task automatic wait_tcr(input int v);
    for (int i = 0; i < 1000; i++) begin
      if (exp_tcr() == v) return;
      step();
    end
    check("wait_tcr_timeout", 32'(exp_tcr()), v);
  endtask

  int n;

  initial begin
    repeat (2) step();
    RST_N  = 1'b1;
    chk_en = 1'b1;
    step();
    check("rst_tcr",   32'(TCR), 0);
    check("rst_ccr",   32'(CCR), 0);
    check("rst_e",     32'(E), 0);
    check("rst_ready", 32'(DUTY_READY), 1);

    // Start counting
    RUN = 1'b1;
    step();
    check("start_tcr", 32'(TCR), 0);
    check("start_e",   32'(E), 1);
    step();
    check("second_tcr", 32'(TCR), (PS == 1) ? 1 : 0);
    check("second_e",   32'(E), 0);

    // Deferred update
    wait_tcr(50);
    DUTY_IN = 7'd20;
    DUTY_VALID = 1'b1;
    step();
    DUTY_VALID = 1'b0;
    check("defer_ready0", 32'(DUTY_READY), 0);
    check("defer_ccr_old", 32'(CCR), 0);
    wait_tcr(0);
    check("defer_ccr_new", 32'(CCR), 20);
    check("defer_e", 32'(E), 1);
    check("defer_ready1", 32'(DUTY_READY), 1);

    // Back-pressure and clamp
    DUTY_IN = 7'd30;
    DUTY_VALID = 1'b1;
    step();
    DUTY_IN = 7'd120;
    check("bp_ready0", 32'(DUTY_READY), 0);
    wait_tcr(TOP);
    wait_tcr(0);
    check("bp_ccr30", 32'(CCR), 30);
    check("bp_ready1", 32'(DUTY_READY), 1);
    step();
    DUTY_VALID = 1'b0;
    check("bp_accept120", 32'(DUTY_READY), 0);
    check("bp_ccr_hold", 32'(CCR), 30);
    wait_tcr(TOP);
    wait_tcr(0);
    check("bp_ccr_clamp", 32'(CCR), 100);
    check("bp_ready_end", 32'(DUTY_READY), 1);

    // Idle transfer
    RUN = 1'b0;
    step();
    check("idle_tcr", 32'(TCR), 0);
    check("idle_e", 32'(E), 0);
    DUTY_IN = 7'd45;
    DUTY_VALID = 1'b1;
    step();
    DUTY_VALID = 1'b0;
    check("idle_ready0", 32'(DUTY_READY), 0);
    check("idle_ccr_old", 32'(CCR), 100);
    step();
    check("idle_ccr45", 32'(CCR), 45);
    check("idle_ready1", 32'(DUTY_READY), 1);
    check("idle_tcr2", 32'(TCR), 0);
    check("idle_e2", 32'(E), 0);

    // Async reset with a duty pending
    RUN = 1'b1;
    step();
    wait_tcr(10);
    DUTY_IN = 7'd60;
    DUTY_VALID = 1'b1;
    step();
    DUTY_VALID = 1'b0;
    check("ar_pending", 32'(DUTY_READY), 0);
    wait_tcr(37);
    #2 RST_N = 1'b0;
    #1;
    check("ar_tcr", 32'(TCR), 0);
    check("ar_ccr", 32'(CCR), 0);
    check("ar_e", 32'(E), 0);
    check("ar_ready", 32'(DUTY_READY), 1);
    step();
    RST_N = 1'b1;
    wait_tcr(TOP);
    wait_tcr(0);
    check("ar_no_transfer", 32'(CCR), 0);
    check("ar_wrap_e", 32'(E), 1);

    // Period length and count-step width
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      n++;
      if (E === 1'b1) break;
    end
`ifdef PWM_PRESCALE_EN
    check("period_clk", 32'(n), 400);
`else
    check("period_clk", 32'(n), 100);
`endif
    wait_tcr(5);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (TCR !== 7'd5) break;
      n++;
    end
`ifdef PWM_PRESCALE_EN
    check("tcr_step_width", 32'(n), 4);
`else
    check("tcr_step_width", 32'(n), 1);
`endif

    RUN = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
